// File: rtl/atm_multi_account.sv
// Multi-account ATM session controller: per-account balance, PIN, try counter and lockout,
// with a per-session withdrawal limit, deposit overflow rejection, cancel and card-removal abort.
module atm_multi_account #(
    parameter int NUM_ACCTS     = 4,
    parameter int BAL_W         = 8,
    parameter int PIN_W         = 4,
    parameter int PIN_SEED      = 6,
    parameter int MAX_TRIES     = 3,
    parameter int SESSION_LIMIT = 100,
    parameter int INIT_BAL      = 0,
    localparam int ID_W         = $clog2(NUM_ACCTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             incard,
    input  logic [ID_W-1:0]  acct_id,
    input  logic             language,
    input  logic [PIN_W-1:0] password,
    input  logic [1:0]       operation,
    input  logic [BAL_W-1:0] amount,
    input  logic [1:0]       confirm,
    input  logic             again,
    output logic             incorrectpassword,
    output logic             nobalance,
    output logic             limit_exceeded,
    output logic             overflow,
    output logic             success,
    output logic             locked,
    output logic [BAL_W-1:0] balance
);

    typedef enum logic [2:0] {
        S_IDLE, S_LANG, S_PIN, S_MENU, S_AMOUNT, S_CONFIRM, S_AGAIN
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     acct_q, acct_d;
    logic                lang_q, lang_d;
    logic [1:0]          op_q, op_d;
    logic [BAL_W-1:0]    amt_q, amt_d;
    logic [BAL_W-1:0]    total_q, total_d;
    logic [BAL_W-1:0]    bal_q   [NUM_ACCTS];
    logic [2:0]          tries_q [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] lock_q;

    logic                bal_we, try_we, lock_set;
    logic [BAL_W-1:0]    bal_wv, cur_bal;
    logic [2:0]          try_wv, cur_tries;
    logic [PIN_W-1:0]    pin_exp;
    logic [BAL_W:0]      dep_sum, wd_total;
    logic                inc_d, nob_d, lim_d, ovf_d, suc_d, lck_d;
    logic [BAL_W-1:0]    balance_d;

    assign cur_bal   = bal_q[acct_q];
    assign cur_tries = tries_q[acct_q];
    assign pin_exp   = PIN_W'(PIN_SEED + int'(acct_q));
    assign dep_sum   = {1'b0, cur_bal} + {1'b0, amt_q};
    assign wd_total  = {1'b0, total_q} + {1'b0, amt_q};

    always_comb begin
        state_d  = state_q;
        acct_d   = acct_q;
        lang_d   = lang_q;
        op_d     = op_q;
        amt_d    = amt_q;
        total_d  = total_q;
        bal_we   = 1'b0;
        bal_wv   = cur_bal;
        try_we   = 1'b0;
        try_wv   = cur_tries;
        lock_set = 1'b0;
        inc_d    = 1'b0;
        nob_d    = 1'b0;
        lim_d    = 1'b0;
        ovf_d    = 1'b0;
        suc_d    = 1'b0;
        lck_d    = 1'b0;

        // Card removal outranks every other transition, including a pending commit
        if (state_q != S_IDLE && !incard) begin
            state_d = S_IDLE;
            total_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (incard) begin
                        acct_d = acct_id;
                        if (lock_q[acct_id]) lck_d = 1'b1;
                        else                 state_d = S_LANG;
                    end
                end
                S_LANG: begin
                    lang_d  = language;
                    state_d = S_PIN;
                end
                S_PIN: begin
                    try_we = 1'b1;
                    if (password == pin_exp) begin
                        try_wv  = '0;
                        state_d = S_MENU;
                    end else begin
                        inc_d = 1'b1;
                        if (cur_tries + 3'd1 == 3'(MAX_TRIES)) begin
                            try_wv   = '0;
                            lock_set = 1'b1;
                            total_d  = '0;
                            state_d  = S_IDLE;
                        end else begin
                            try_wv = cur_tries + 3'd1;
                        end
                    end
                end
                S_MENU: begin
                    op_d = operation;
                    case (operation)
                        2'b01:   state_d = S_CONFIRM;
                        2'b11: begin
                            state_d = S_IDLE;
                            total_d = '0;
                        end
                        default: state_d = S_AMOUNT;
                    endcase
                end
                S_AMOUNT: begin
                    amt_d   = amount;
                    state_d = S_CONFIRM;
                end
                S_CONFIRM: begin
                    if (confirm == 2'b00) begin
                        state_d = S_AGAIN;
                    end else if (confirm == 2'b11) begin
                        state_d = S_AGAIN;
                        case (op_q)
                            2'b00: begin
                                if (dep_sum[BAL_W]) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    bal_we = 1'b1;
                                    bal_wv = dep_sum[BAL_W-1:0];
                                    suc_d  = 1'b1;
                                end
                            end
                            2'b10: begin
                                if (amt_q > cur_bal) begin
                                    nob_d = 1'b1;
                                end else if (wd_total > (BAL_W+1)'(SESSION_LIMIT)) begin
                                    lim_d = 1'b1;
                                end else begin
                                    bal_we  = 1'b1;
                                    bal_wv  = cur_bal - amt_q;
                                    total_d = wd_total[BAL_W-1:0];
                                    suc_d   = 1'b1;
                                end
                            end
                            default: suc_d = 1'b1;
                        endcase
                    end
                end
                S_AGAIN: begin
                    if (again) begin
                        state_d = S_MENU;
                    end else begin
                        state_d = S_IDLE;
                        total_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Display follows the state being entered so a commit shows on the same edge
        case (state_d)
            S_MENU, S_AMOUNT, S_CONFIRM, S_AGAIN: balance_d = bal_we ? bal_wv : cur_bal;
            default:                              balance_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            acct_q            <= '0;
            lang_q            <= 1'b0;
            op_q              <= '0;
            amt_q             <= '0;
            total_q           <= '0;
            lock_q            <= '0;
            for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
                bal_q[i]   <= BAL_W'(INIT_BAL);
                tries_q[i] <= '0;
            end
            incorrectpassword <= 1'b0;
            nobalance         <= 1'b0;
            limit_exceeded    <= 1'b0;
            overflow          <= 1'b0;
            success           <= 1'b0;
            locked            <= 1'b0;
            balance           <= '0;
        end else begin
            state_q           <= state_d;
            acct_q            <= acct_d;
            lang_q            <= lang_d;
            op_q              <= op_d;
            amt_q             <= amt_d;
            total_q           <= total_d;
            if (bal_we)   bal_q[acct_q]   <= bal_wv;
            if (try_we)   tries_q[acct_q] <= try_wv;
            if (lock_set) lock_q[acct_q]  <= 1'b1;
            incorrectpassword <= inc_d;
            nobalance         <= nob_d;
            limit_exceeded    <= lim_d;
            overflow          <= ovf_d;
            success           <= suc_d;
            locked            <= lck_d;
            balance           <= balance_d;
        end
    end

endmodule

// File: tb/tb_atm_multi_account.sv
// Table-driven bench for atm_multi_account: per-cycle vectors through an expected-value queue,
// plus a hand-timed asynchronous reset in the middle of a pending transaction.
module tb_atm_multi_account;

    logic       clk = 1'b0;
    logic       rst;
    logic       incard;
    logic [1:0] acct_id;
    logic       language;
    logic [3:0] password;
    logic [1:0] operation;
    logic [7:0] amount;
    logic [1:0] confirm;
    logic       again;
    logic       incorrectpassword, nobalance, limit_exceeded, overflow, success, locked;
    logic [7:0] balance;

    // pulse vector order: {incorrectpassword, nobalance, limit_exceeded, overflow, success, locked}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] INC  = 6'b100000;
    localparam logic [5:0] NOB  = 6'b010000;
    localparam logic [5:0] LIM  = 6'b001000;
    localparam logic [5:0] OVF  = 6'b000100;
    localparam logic [5:0] SUC  = 6'b000010;
    localparam logic [5:0] LCK  = 6'b000001;

    typedef struct {
        logic       ic;
        logic [1:0] id;
        logic [3:0] pw;
        logic [1:0] op;
        logic [7:0] amt;
        logic [1:0] cf;
        logic       ag;
        logic [5:0] pul;
        logic [7:0] bal;
        string      grp;
    } vec_t;

    vec_t  tbl[$];
    vec_t  exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    string grp   = "";

    atm_multi_account dut (
        .clk(clk), .rst(rst), .incard(incard), .acct_id(acct_id), .language(language),
        .password(password), .operation(operation), .amount(amount), .confirm(confirm),
        .again(again), .incorrectpassword(incorrectpassword), .nobalance(nobalance),
        .limit_exceeded(limit_exceeded), .overflow(overflow), .success(success),
        .locked(locked), .balance(balance)
    );

    always #5 clk = ~clk;

    task automatic add(input logic ic, input logic [1:0] id, input logic [3:0] pw,
                       input logic [1:0] op, input logic [7:0] amt, input logic [1:0] cf,
                       input logic ag, input logic [5:0] pul, input logic [7:0] bal);
        vec_t v;
        v.ic = ic; v.id = id; v.pw = pw; v.op = op; v.amt = amt; v.cf = cf; v.ag = ag;
        v.pul = pul; v.bal = bal; v.grp = grp;
        tbl.push_back(v);
    endtask

    task automatic check(input vec_t e);
        logic [5:0] got;
        got = {incorrectpassword, nobalance, limit_exceeded, overflow, success, locked};
        n_vec++;
        if (got !== e.pul || balance !== e.bal) begin
            n_bad++;
            $display("FAIL %s #%0d: pulses=%b balance=%0d, expected pulses=%b balance=%0d",
                     e.grp, n_vec, got, balance, e.pul, e.bal);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        incard = v.ic; acct_id = v.id; language = v.id[0]; password = v.pw;
        operation = v.op; amount = v.amt; confirm = v.cf; again = v.ag;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(e);
    endtask

    task automatic run_table();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        vec_t zero;
        zero.ic = 0; zero.id = 0; zero.pw = 0; zero.op = 0; zero.amt = 0; zero.cf = 0;
        zero.ag = 0; zero.pul = NONE; zero.bal = 0;

        rst = 1'b1; incard = 0; acct_id = 0; language = 0; password = 0;
        operation = 0; amount = 0; confirm = 0; again = 0;
        repeat (2) @(posedge clk);
        #1;
        zero.grp = "reset state";
        check(zero);
        rst = 1'b0;

        grp = "acct1 deposit/withdraw";
        add(1,1,0,0,0,0,0,NONE,0);   add(1,1,0,0,0,0,0,NONE,0);
        add(1,1,7,0,0,0,0,NONE,0);   add(1,1,7,0,0,0,0,NONE,0);
        add(1,1,7,0,34,0,0,NONE,0);  add(1,1,7,0,34,3,0,SUC,34);
        add(1,1,7,0,0,0,1,NONE,34);  add(1,1,7,2,0,0,0,NONE,34);
        add(1,1,7,2,51,0,0,NONE,34); add(1,1,7,2,51,3,0,NOB,34);
        add(1,1,7,0,0,0,0,NONE,0);
        grp = "acct0 untouched";
        add(1,0,0,0,0,0,0,NONE,0);   add(1,0,0,0,0,0,0,NONE,0);
        add(1,0,6,0,0,0,0,NONE,0);   add(1,0,6,3,0,0,0,NONE,0);
        grp = "acct2 lockout";
        add(1,2,0,0,0,0,0,NONE,0);   add(1,2,0,0,0,0,0,NONE,0);
        add(1,2,3,0,0,0,0,INC,0);    add(1,2,3,0,0,0,0,INC,0);
        add(1,2,3,0,0,0,0,INC,0);    add(1,2,0,0,0,0,0,LCK,0);
        add(0,2,0,0,0,0,0,NONE,0);
        grp = "acct3 unaffected";
        add(1,3,0,0,0,0,0,NONE,0);   add(1,3,0,0,0,0,0,NONE,0);
        add(1,3,9,0,0,0,0,NONE,0);   add(1,3,9,3,0,0,0,NONE,0);
        grp = "session limit";
        add(1,0,0,0,0,0,0,NONE,0);   add(1,0,0,0,0,0,0,NONE,0);
        add(1,0,6,0,0,0,0,NONE,0);   add(1,0,6,0,0,0,0,NONE,0);
        add(1,0,6,0,200,0,0,NONE,0); add(1,0,6,0,200,3,0,SUC,200);
        add(1,0,6,0,0,0,1,NONE,200); add(1,0,6,2,0,0,0,NONE,200);
        add(1,0,6,2,60,0,0,NONE,200); add(1,0,6,2,60,3,0,SUC,140);
        add(1,0,6,0,0,0,1,NONE,140); add(1,0,6,2,0,0,0,NONE,140);
        add(1,0,6,2,41,0,0,NONE,140); add(1,0,6,2,41,3,0,LIM,140);
        add(1,0,6,0,0,0,1,NONE,140); add(1,0,6,2,0,0,0,NONE,140);
        add(1,0,6,2,40,0,0,NONE,140); add(1,0,6,2,40,3,0,SUC,100);
        add(1,0,6,0,0,0,0,NONE,0);
        grp = "new session full withdraw";
        add(1,0,0,0,0,0,0,NONE,0);   add(1,0,0,0,0,0,0,NONE,0);
        add(1,0,6,0,0,0,0,NONE,100); add(1,0,6,2,0,0,0,NONE,100);
        add(1,0,6,2,100,0,0,NONE,100); add(1,0,6,2,100,3,0,SUC,0);
        add(1,0,6,0,0,0,0,NONE,0);
        grp = "deposit overflow";
        add(1,3,0,0,0,0,0,NONE,0);   add(1,3,0,0,0,0,0,NONE,0);
        add(1,3,9,0,0,0,0,NONE,0);   add(1,3,9,0,0,0,0,NONE,0);
        add(1,3,9,0,250,0,0,NONE,0); add(1,3,9,0,250,3,0,SUC,250);
        add(1,3,9,0,0,0,1,NONE,250); add(1,3,9,0,0,0,0,NONE,250);
        add(1,3,9,0,10,0,0,NONE,250); add(1,3,9,0,10,3,0,OVF,250);
        add(1,3,9,0,0,0,1,NONE,250); add(1,3,9,0,0,0,0,NONE,250);
        add(1,3,9,0,5,0,0,NONE,250); add(1,3,9,0,5,3,0,SUC,255);
        add(1,3,9,0,0,0,1,NONE,255); add(1,3,9,2,0,0,0,NONE,255);
        add(1,3,9,2,0,0,0,NONE,255); add(1,3,9,2,0,3,0,SUC,255);
        add(1,3,9,0,0,0,0,NONE,0);
        grp = "wait/cancel/abort";
        add(1,1,0,0,0,0,0,NONE,0);   add(1,1,0,0,0,0,0,NONE,0);
        add(1,1,7,0,0,0,0,NONE,34);  add(1,1,7,2,0,0,0,NONE,34);
        add(1,1,7,2,20,0,0,NONE,34); add(1,1,7,2,20,1,0,NONE,34);
        add(1,1,7,2,20,2,0,NONE,34); add(1,1,7,2,20,0,0,NONE,34);
        add(1,1,7,0,0,0,1,NONE,34);  add(1,1,7,2,0,0,0,NONE,34);
        add(1,1,7,2,20,0,0,NONE,34); add(0,1,7,2,20,3,0,NONE,0);
        grp = "enquiry after abort";
        add(1,1,0,0,0,0,0,NONE,0);   add(1,1,0,0,0,0,0,NONE,0);
        add(1,1,7,0,0,0,0,NONE,34);  add(1,1,7,1,0,0,0,NONE,34);
        add(1,1,7,1,0,3,0,SUC,34);   add(1,1,7,0,0,0,0,NONE,0);
        grp = "try counter persists";
        add(1,0,0,0,0,0,0,NONE,0);   add(1,0,0,0,0,0,0,NONE,0);
        add(1,0,0,0,0,0,0,INC,0);    add(1,0,0,0,0,0,0,INC,0);
        add(0,0,0,0,0,0,0,NONE,0);
        add(1,0,0,0,0,0,0,NONE,0);   add(1,0,0,0,0,0,0,NONE,0);
        add(1,0,0,0,0,0,0,INC,0);    add(1,0,0,0,0,0,0,LCK,0);
        add(0,0,0,0,0,0,0,NONE,0);
        grp = "pre-reset confirm";
        add(1,3,0,0,0,0,0,NONE,0);   add(1,3,0,0,0,0,0,NONE,0);
        add(1,3,9,0,0,0,0,NONE,255); add(1,3,9,0,0,0,0,NONE,255);
        add(1,3,9,0,1,0,0,NONE,255);
        run_table();

        // Reset lands between edges while CONFIRM is pending; outputs must clear without a clock
        #3 rst = 1'b1;
        #1;
        zero.grp = "async reset mid-confirm";
        check(zero);
        incard = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        grp = "after reset";
        add(1,0,0,0,0,0,0,NONE,0);   add(1,0,0,0,0,0,0,NONE,0);
        add(1,0,6,0,0,0,0,NONE,0);   add(1,0,6,3,0,0,0,NONE,0);
        add(1,3,0,0,0,0,0,NONE,0);   add(1,3,0,0,0,0,0,NONE,0);
        add(1,3,9,0,0,0,0,NONE,0);   add(1,3,9,3,0,0,0,NONE,0);
        add(1,2,0,0,0,0,0,NONE,0);   add(1,2,0,0,0,0,0,NONE,0);
        add(1,2,8,0,0,0,0,NONE,0);   add(1,2,8,3,0,0,0,NONE,0);
        add(0,0,0,0,0,0,0,NONE,0);
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
